// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: DIGIT bits per clock through one ripple slice, start/busy/done handshake.
// Optional add/subtract mode with signed overflow flag when ADD_SUB_EN is defined.
module digit_serial_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef ADD_SUB_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
   logic             ovf_q, ovf_d;
   logic [DIGIT:0]   dig_c;
   logic [WIDTH-1:0] acc_shift_c;
   logic [WIDTH-1:0] b_load_c;
   logic             carry_load_c;

   // Single DIGIT-bit ripple slice over the low digit of the operand shift registers
   always_comb begin
      dig_c       = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
      acc_shift_c = (acc_q >> DIGIT) | (WIDTH'(dig_c[DIGIT-1:0]) << (WIDTH - DIGIT));
   end

`ifdef ADD_SUB_EN
   assign b_load_c     = sub ? ~b : b;
   assign carry_load_c = sub ? 1'b1 : cin;
`else
   assign b_load_c     = b;
   assign carry_load_c = cin;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               a_d     = a;
               b_d     = b_load_c;
               carry_d = carry_load_c;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            acc_d   = acc_shift_c;
            carry_d = dig_c[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NDIG - 1)) begin
               state_d = S_DONE;
               sum_d   = acc_shift_c;
               cout_d  = dig_c[DIGIT];
               // Carry into the MSB is a^b^s at that bit; overflow when it differs from carry out
               ovf_d   = dig_c[DIGIT] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_c[DIGIT-1];
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d != S_RUN);
      busy_d  = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;
`ifdef ADD_SUB_EN
   assign ovf   = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: transaction-level reference model plus directed and random stimulus.
// Exercises the ADD_SUB_EN ports when that macro is defined.
module tb_digit_serial_adder;

   localparam int unsigned W  = 16;
   localparam int unsigned D  = 4;
   localparam int unsigned ND = W / D;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         start, cin, ready, busy, done, cout;
   logic [W-1:0] a, b, sum;
`ifdef ADD_SUB_EN
   logic sub, ovf, d1_ovf, d4_ovf;
`endif

   logic       s_start, s_cin;
   logic [3:0] s_a, s_b, d1_sum, d4_sum;
   logic       d1_ready, d1_busy, d1_done, d1_cout;
   logic       d4_ready, d4_busy, d4_done, d4_cout;

   digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADD_SUB_EN
      .sub(sub), .ovf(ovf),
`endif
      .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout));

   digit_serial_adder #(.WIDTH(4), .DIGIT(1)) dut_w4d1 (
      .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
`ifdef ADD_SUB_EN
      .sub(1'b0), .ovf(d1_ovf),
`endif
      .ready(d1_ready), .busy(d1_busy), .done(d1_done), .sum(d1_sum), .cout(d1_cout));

   digit_serial_adder #(.WIDTH(4), .DIGIT(4)) dut_w4d4 (
      .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
`ifdef ADD_SUB_EN
      .sub(1'b0), .ovf(d4_ovf),
`endif
      .ready(d4_ready), .busy(d4_busy), .done(d4_done), .sum(d4_sum), .cout(d4_cout));

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
   endtask

   // Reference result {ovf, cout, sum} from plain integer arithmetic
   function automatic logic [W+1:0] calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
      logic [W-1:0] yy;
      logic         c0;
      logic [W:0]   r;
      logic         ov;
      yy = sb ? ~y : y;
      c0 = sb ? 1'b1 : ci;
      r  = {1'b0, x} + {1'b0, yy} + (W+1)'(c0);
      ov = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
      return {ov, r};
   endfunction

   // Transaction model: a result appears NDIG cycles after acceptance, held until the next one
   logic           m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
   logic [W-1:0]   m_sum  = '0;
   logic [W+1:0]   m_pend = '0;
   int             m_left = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               {m_ovf, m_cout, m_sum} <= m_pend;
            end
            m_left <= m_left - 1;
         end else if (start) begin
`ifdef ADD_SUB_EN
            m_pend <= calc(a, b, cin, sub);
`else
            m_pend <= calc(a, b, cin, 1'b0);
`endif
            m_busy <= 1'b1;
            m_left <= ND;
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_ready", 32'(ready), 32'(!m_busy));
      chk("cyc_busy",  32'(busy),  32'(m_busy));
      chk("cyc_done",  32'(done),  32'(m_done));
      chk("cyc_sum",   32'(sum),   32'(m_sum));
      chk("cyc_cout",  32'(cout),  32'(m_cout));
`ifdef ADD_SUB_EN
      chk("cyc_ovf",   32'(ovf),   32'(m_ovf));
`endif
   end

   // Issue one operation from between edges; returns in the done cycle
   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                     input logic sb, input logic pk, output int dcyc);
      logic [W+1:0] e;
      int           k;
      e    = calc(x, y, ci, sb);
      k    = 0;
      dcyc = -1;
      for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
      chk("ready_before_start", 32'(ready), 32'd1);
      start = 1'b1; a = x; b = y; cin = ci;
`ifdef ADD_SUB_EN
      sub = sb;
`endif
      @(posedge clk);
      #2 start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      for (int i = 1; i <= int'(ND) + 4 && k == 0; i++) begin
         @(negedge clk);
         if (done) begin k = i; dcyc = cyc; end
         if (pk && i == 2) begin start = 1'b1; a = W'($urandom); b = W'($urandom); end
         if (pk && i == 3) start = 1'b0;
      end
      start = 1'b0;
      chk("latency", 32'(k), 32'(ND + 1));
      chk("op_sum",  32'(sum),  32'(e[W-1:0]));
      chk("op_cout", 32'(cout), 32'(e[W]));
`ifdef ADD_SUB_EN
      chk("op_ovf",  32'(ovf),  32'(e[W+1]));
`endif
   endtask

   task automatic small_op(input logic [3:0] x, input logic [3:0] y, input logic ci,
                           input logic [3:0] es, input logic ec);
      int k1, k4;
      k1 = 0; k4 = 0;
      s_start = 1'b1; s_a = x; s_b = y; s_cin = ci;
      @(posedge clk);
      #2 s_start = 1'b0; s_a = 4'($urandom); s_b = 4'($urandom); s_cin = 1'($urandom);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (d1_done && k1 == 0) k1 = i;
         if (d4_done && k4 == 0) k4 = i;
      end
      chk("w4d1_latency", 32'(k1), 32'd5);
      chk("w4d4_latency", 32'(k4), 32'd2);
      chk("w4d1_sum",  32'(d1_sum),  32'(es));
      chk("w4d1_cout", 32'(d1_cout), 32'(ec));
      chk("w4d4_sum",  32'(d4_sum),  32'(es));
      chk("w4d4_cout", 32'(d4_cout), 32'(ec));
   endtask

   initial begin
      int  t0, t1;
      logic seen;
      start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADD_SUB_EN
      sub = 1'b0;
`endif
      s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
      rst = 1'b1;

      chk("pin_model_ffff_1",  32'(calc(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);
      chk("pin_model_1234",    32'(calc(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'h05555);
      chk("pin_model_sub_5_7", 32'(calc(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_sum",   32'(sum),   32'd0);
      chk("rst_cout",  32'(cout),  32'd0);
      #2 rst = 1'b0;
      @(negedge clk);

      op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, t0);
      chk("lit_zero_sum", 32'(sum), 32'h0000);
      op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, t0);
      chk("lit_wrap_sum", 32'(sum), 32'h0000);
      chk("lit_wrap_cout", 32'(cout), 32'd1);
      op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, t0);
      chk("lit_max_sum", 32'(sum), 32'hFFFF);
      chk("lit_max_cout", 32'(cout), 32'd1);
      op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, t0);
      chk("lit_5555_sum", 32'(sum), 32'h5555);

      // start pulsed mid-RUN must be ignored
      op(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b1, t0);
      chk("lit_poke_sum", 32'(sum), 32'h1000);

      // back-to-back start in the DONE cycle
      op(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0, t0);
      op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, t1);
      chk("b2b_done_gap", 32'(t1 - t0), 32'(ND + 1));
      chk("lit_b2b_sum", 32'(sum), 32'h0001);

      // reset after two digits aborts without a visible result
      @(negedge clk);
      start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      @(posedge clk);
      #2 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy",  32'(busy),  32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_sum",   32'(sum),   32'd0);
      chk("abort_cout",  32'(cout),  32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b0, t0);
      chk("lit_after_abort_sum", 32'(sum), 32'h0000);
      chk("lit_after_abort_cout", 32'(cout), 32'd1);

`ifdef ADD_SUB_EN
      op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, t0);
      chk("lit_sub_sum", 32'(sum), 32'hFFFE);
      chk("lit_sub_cout", 32'(cout), 32'd0);
      chk("lit_sub_ovf", 32'(ovf), 32'd0);
      op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, t0);
      chk("lit_sub_ovf_sum", 32'(sum), 32'h7FFF);
      chk("lit_sub_ovf_flag", 32'(ovf), 32'd1);
      op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, t0);
      chk("lit_add_ovf_sum", 32'(sum), 32'h8000);
      chk("lit_add_ovf_flag", 32'(ovf), 32'd1);
`endif

      small_op(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
      small_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
      small_op(4'b1100, 4'b0011, 1'b1, 4'b0000, 1'b1);

      for (int n = 0; n < 150; n++) begin
         logic sb;
         sb = 1'b0;
`ifdef ADD_SUB_EN
         sb = ($urandom_range(0, 3) == 0);
`endif
         op(W'($urandom), W'($urandom), 1'($urandom), sb, ($urandom_range(0, 7) == 0), t0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle successor to the 4-bit combinational adder. Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through a single DIGIT-bit ripple slice and a registered inter-digit carry. Trades latency for area in wide datapaths. Uses a start/busy/done handshake and holds the result until the next accepted operation.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per clock; 1 gives bit-serial operation, DIGIT=WIDTH gives one digit cycle.
NDIG (localparam), WIDTH/DIGIT, number of digit cycles.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; accepted only while ready=1.
a  in  WIDTH  operand A; sampled on the accepting edge.
b  in  WIDTH  operand B; sampled on the accepting edge.
cin  in  1  carry-in; sampled on the accepting edge.
ready  out  1  high in IDLE and DONE; a start is accepted when ready=1.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse; sum/cout are valid from this cycle on.
sum  out  WIDTH  registered result; held until the final digit of the next operation.
cout  out  1  registered carry-out of the MSB digit; held like sum.

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, digit counter=0, internal carry=0, operand shift registers=0. Reset during RUN aborts the operation with no partial result visible.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, latch a, b, and cin (into the carry register), clear the counter, and go to RUN. Otherwise stay.
- RUN: each edge computes {c, s} = a_dig + b_dig + carry on the low DIGIT bits of the operand shift registers.
  - Shift both operands right by DIGIT; shift s into the MSB end of an internal accumulator.
  - Store c in carry and increment the counter.
  - On the edge that processes digit NDIG-1, copy the completed accumulator to sum and the final c to cout, then go to DONE.
- DONE: done=1 for exactly this cycle, ready=1. If start=1, accept a new operation exactly as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: accepting edge E; done is high in the cycle after edge E+NDIG. Throughput is one result per NDIG+1 cycles, including back-to-back starts.
- start while busy=1 is ignored. It is not queued and does not disturb the operands.
- a, b, and cin may change freely after the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1. {cout,sum} equals a+b+cin for all inputs.
- sum and cout are not modified during RUN until the final digit edge; the previous result stays readable.

Optional Feature:
Macro ADD_SUB_EN.
- Defined: adds input port sub (1 bit, sampled with the operands) and output port ovf (1 bit, registered, reset 0, updated with sum).
  - sub=1: B is latched as ~b and the carry register is loaded with 1 (cin ignored), giving a-b. cout=1 means no borrow.
  - ovf = signed two's-complement overflow of the operation, from the carry into and out of bit WIDTH-1 on the last digit.
- Undefined: neither port exists; the block is add-only as described above.

Test Plan:
- WIDTH=16, DIGIT=4: reset, then start with a=0x0000, b=0x0000, cin=0 -> done 4 cycles after the accepting edge's next cycle; sum=0x0000, cout=0; ready=1, busy=0 throughout reset.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Then a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0.
- Start pulse during RUN with different operands -> ignored; the result matches the first operands. A start in the DONE cycle -> next done exactly 5 cycles after the previous done.
- rst asserted mid-RUN (after 2 digits) -> immediately state=IDLE, sum=0, cout=0, done never pulses. The next operation is correct.
- Configurations WIDTH=4/DIGIT=1 and WIDTH=4/DIGIT=4 replay the 4-bit vectors: 1111+0001 -> 0000/cout=1, 1111+1111+1 -> 1111/cout=1, 1100+0011+1 -> 0000/cout=1. Latency is 4 and 1 digit cycles respectively.
- ADD_SUB_EN, WIDTH=16: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1. sub=0, a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
